// File: rtl/geofence_frame_feeder.sv
//==============================================================================
// Module  : geofence_frame_feeder
// Brief   : Collects host (X,Y) points into 7-point frames held in two
//           ping-pong slots, replays each frame to the geofence engine, waits
//           for the engine result (or a timeout) and returns it to the host
//           tagged with a wrapping frame ID.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module geofence_frame_feeder #(
    parameter int FRAME_PTS = 7,
    parameter int TIMEOUT   = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    output logic [9:0]  gf_x,
    output logic [9:0]  gf_y,
    input  logic        gf_valid,
    input  logic        gf_is_inside,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_inside,
    output logic        res_timeout,
    output logic [7:0]  res_frame_id,
    output logic        busy
);

    localparam int c_IDX_W = $clog2(FRAME_PTS);
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam int c_PT_W  = 20;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_PTS - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT  = c_CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    // Two frame slots; a slot's contents are only meaningful while its full flag is set
    logic [c_PT_W-1:0]  mem_q [0:1][0:FRAME_PTS-1];

    state_t             state_q,       state_d;
    logic [1:0]         full_q,        full_d;
    logic               wr_slot_q,     wr_slot_d;
    logic [c_IDX_W-1:0] wr_idx_q,      wr_idx_d;
    logic               rd_slot_q,     rd_slot_d;
    logic [c_IDX_W-1:0] snd_idx_q,     snd_idx_d;
    logic [c_CNT_W-1:0] cnt_q,         cnt_d;
    logic [9:0]         gf_x_q,        gf_x_d;
    logic [9:0]         gf_y_q,        gf_y_d;
    logic               res_valid_q,   res_valid_d;
    logic               res_inside_q,  res_inside_d;
    logic               res_timeout_q, res_timeout_d;
    logic [7:0]         frame_id_q,    frame_id_d;

    logic               w_accept;
    logic [c_PT_W-1:0]  w_rd_point;

    assign in_ready     = ~full_q[wr_slot_q];
    assign w_accept     = in_valid & in_ready;
    assign w_rd_point   = mem_q[rd_slot_q][snd_idx_q];

    assign gf_x         = gf_x_q;
    assign gf_y         = gf_y_q;
    assign res_valid    = res_valid_q;
    assign res_inside   = res_inside_q;
    assign res_timeout  = res_timeout_q;
    assign res_frame_id = frame_id_q;
    assign busy         = (state_q != ST_IDLE);

    // Point storage write port; no reset needed since the full flags gate all reads
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[wr_slot_q][wr_idx_q] <= {in_x, in_y};
        end
    end

    // Next-state logic for the fill side, the send FSM and the result registers
    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        wr_slot_d     = wr_slot_q;
        wr_idx_d      = wr_idx_q;
        rd_slot_d     = rd_slot_q;
        snd_idx_d     = snd_idx_q;
        cnt_d         = cnt_q;
        gf_x_d        = gf_x_q;
        gf_y_d        = gf_y_q;
        res_valid_d   = res_valid_q;
        res_inside_d  = res_inside_q;
        res_timeout_d = res_timeout_q;
        frame_id_d    = frame_id_q;

        // Fill side: the last point of a frame seals the slot and moves to the other one
        if (w_accept) begin
            if (wr_idx_q == c_LAST_IDX) begin
                full_d[wr_slot_q] = 1'b1;
                wr_idx_d          = '0;
                wr_slot_d         = ~wr_slot_q;
            end else begin
                wr_idx_d = wr_idx_q + c_IDX_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_slot_q]) begin
                    state_d   = ST_SEND;
                    snd_idx_d = '0;
                end
            end

            ST_SEND: begin
                gf_x_d = w_rd_point[19:10];
                gf_y_d = w_rd_point[9:0];
                if (snd_idx_q == c_LAST_IDX) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    snd_idx_d = snd_idx_q + c_IDX_W'(1);
                end
            end

            ST_WAIT: begin
                // Timeout fires on the cycle in which the counter holds TIMEOUT
                if (gf_valid) begin
                    res_inside_d  = gf_is_inside;
                    res_timeout_d = 1'b0;
                    res_valid_d   = 1'b1;
                    state_d       = ST_REPORT;
                end else if (cnt_q == c_TIMEOUT) begin
                    res_inside_d  = 1'b0;
                    res_timeout_d = 1'b1;
                    res_valid_d   = 1'b1;
                    state_d       = ST_REPORT;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            ST_REPORT: begin
                // The slot being released is never the slot being sealed this cycle
                if (res_ready) begin
                    full_d[rd_slot_q] = 1'b0;
                    rd_slot_d         = ~rd_slot_q;
                    frame_id_d        = frame_id_q + 8'd1;
                    res_valid_d       = 1'b0;
                    state_d           = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            full_q        <= '0;
            wr_slot_q     <= 1'b0;
            wr_idx_q      <= '0;
            rd_slot_q     <= 1'b0;
            snd_idx_q     <= '0;
            cnt_q         <= '0;
            gf_x_q        <= '0;
            gf_y_q        <= '0;
            res_valid_q   <= 1'b0;
            res_inside_q  <= 1'b0;
            res_timeout_q <= 1'b0;
            frame_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            full_q        <= full_d;
            wr_slot_q     <= wr_slot_d;
            wr_idx_q      <= wr_idx_d;
            rd_slot_q     <= rd_slot_d;
            snd_idx_q     <= snd_idx_d;
            cnt_q         <= cnt_d;
            gf_x_q        <= gf_x_d;
            gf_y_q        <= gf_y_d;
            res_valid_q   <= res_valid_d;
            res_inside_q  <= res_inside_d;
            res_timeout_q <= res_timeout_d;
            frame_id_q    <= frame_id_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_geofence_frame_feeder.sv
//==============================================================================
// Module  : tb_geofence_frame_feeder
// Brief   : Directed self-checking bench for geofence_frame_feeder.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_geofence_frame_feeder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_x;
    logic [9:0] in_y;
    logic [9:0] gf_x;
    logic [9:0] gf_y;
    logic       gf_valid;
    logic       gf_is_inside;
    logic       res_valid;
    logic       res_ready;
    logic       res_inside;
    logic       res_timeout;
    logic [7:0] res_frame_id;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Frames expected on the engine port, in send order; point k in bits [k*20 +: 20]
    logic [139:0] exp_q[$];

    geofence_frame_feeder #(
        .FRAME_PTS (7),
        .TIMEOUT   (63)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .gf_x         (gf_x),
        .gf_y         (gf_y),
        .gf_valid     (gf_valid),
        .gf_is_inside (gf_is_inside),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_inside   (res_inside),
        .res_timeout  (res_timeout),
        .res_frame_id (res_frame_id),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [139:0] mk_seq(input int b);
        logic [139:0] f;
        f = '0;
        for (int k = 0; k < 7; k++) begin
            f[k*20 +: 20] = {10'(b + k), 10'(b + 50 + k)};
        end
        return f;
    endfunction

    // Offer one point and hold it until accepted; leaves in_valid high
    task automatic push_pt(input logic [19:0] p);
        int n;
        in_x     = p[19:10];
        in_y     = p[9:0];
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!in_ready) check_val("push_ready_bound", in_ready, 1);
        tick();
    endtask

    task automatic push_frame(input logic [139:0] f);
        for (int k = 0; k < 7; k++) push_pt(f[k*20 +: 20]);
        in_valid = 1'b0;
        exp_q.push_back(f);
    endtask

    task automatic wait_res(input int bound);
        int n;
        n = 0;
        while (!res_valid && n < bound) begin
            tick();
            n++;
        end
        check_val("res_valid_seen", res_valid, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_val("res_dropped", res_valid, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        in_valid     = 1'b0;
        res_ready    = 1'b0;
        gf_valid     = 1'b0;
        gf_is_inside = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        tick();
    endtask

    // Engine-port monitor: after each IDLE->SEND, the next 7 samples must carry the queued frame
    initial begin : g_monitor
        logic         prev_busy;
        int           k;
        logic [139:0] cur;
        prev_busy = 1'b0;
        k         = -1;
        cur       = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                k         = -1;
                prev_busy = 1'b0;
            end else begin
                if (k >= 0) begin
                    check_val("gf_point", {12'd0, gf_x, gf_y}, {12'd0, cur[k*20 +: 20]});
                    k++;
                    if (k == 7) k = -1;
                end
                if (busy && !prev_busy) begin
                    check_val("send_has_frame", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        k   = 0;
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : g_watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : g_main
        logic [139:0] f1, fa, fb, fc, fe, ff, fi;
        int t1x[7];
        int t1y[7];
        t1x = '{5, 0, 10, 15, 10, 0, 0};
        t1y = '{5, 0, 0, 5, 10, 10, 5};
        in_x  = '0;
        in_y  = '0;
        reset = 1'b1;
        do_reset();

        // Reset state
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_gf_x", gf_x, 0);
        check_val("rst_gf_y", gf_y, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res_inside", res_inside, 0);
        check_val("rst_res_timeout", res_timeout, 0);
        check_val("rst_frame_id", res_frame_id, 0);
        check_val("rst_busy", busy, 0);

        // Single frame with engine result three cycles into WAIT
        f1 = '0;
        for (int k = 0; k < 7; k++) f1[k*20 +: 20] = {10'(t1x[k]), 10'(t1y[k])};
        push_frame(f1);
        check_val("t1_busy_at_t", busy, 0);
        tick();
        check_val("t1_busy_at_t1", busy, 1);
        repeat (7) tick();
        check_val("t1_wait_no_res", res_valid, 0);
        tick();
        tick();
        check_val("t1_res_before_strobe", res_valid, 0);
        gf_valid     = 1'b1;
        gf_is_inside = 1'b1;
        tick();
        gf_valid     = 1'b0;
        gf_is_inside = 1'b0;
        check_val("t1_res_valid", res_valid, 1);
        check_val("t1_res_inside", res_inside, 1);
        check_val("t1_res_timeout", res_timeout, 0);
        check_val("t1_frame_id", res_frame_id, 0);
        repeat (2) tick();
        check_val("t1_hold_valid", res_valid, 1);
        check_val("t1_hold_inside", res_inside, 1);
        handshake();
        check_val("t1_id_after", res_frame_id, 1);

        // Timeout: counter reaches TIMEOUT at WAIT+63, result visible at WAIT+64
        push_frame(mk_seq(300));
        repeat (8) tick();
        repeat (63) tick();
        check_val("t3_res_early", res_valid, 0);
        tick();
        check_val("t3_res_valid", res_valid, 1);
        check_val("t3_res_timeout", res_timeout, 1);
        check_val("t3_res_inside", res_inside, 0);
        check_val("t3_frame_id", res_frame_id, 1);
        handshake();

        // Spurious strobes in SEND and REPORT are ignored
        push_frame(mk_seq(400));
        tick();
        tick();
        tick();
        gf_valid     = 1'b1;
        gf_is_inside = 1'b1;
        tick();
        gf_valid     = 1'b0;
        gf_is_inside = 1'b0;
        repeat (4) tick();
        check_val("t4_no_early_res", res_valid, 0);
        check_val("t4_busy", busy, 1);
        repeat (3) tick();
        gf_valid     = 1'b1;
        gf_is_inside = 1'b0;
        tick();
        gf_valid     = 1'b0;
        check_val("t4_res_valid", res_valid, 1);
        check_val("t4_res_inside", res_inside, 0);
        check_val("t4_res_timeout", res_timeout, 0);
        check_val("t4_frame_id", res_frame_id, 2);
        gf_valid     = 1'b1;
        gf_is_inside = 1'b1;
        repeat (2) tick();
        gf_valid     = 1'b0;
        gf_is_inside = 1'b0;
        check_val("t4_report_inside", res_inside, 0);
        check_val("t4_report_valid", res_valid, 1);
        handshake();

        // Backpressure: 21 points with the host not taking results
        do_reset();
        fa = mk_seq(1);
        fb = mk_seq(101);
        fc = mk_seq(201);
        push_frame(fa);
        push_frame(fb);
        check_val("t2_ready_both_full", in_ready, 0);
        in_x     = fc[19:10];
        in_y     = fc[9:0];
        in_valid = 1'b1;
        repeat (3) tick();
        check_val("t2_ready_stalled", in_ready, 0);
        wait_res(200);
        check_val("t2_id0", res_frame_id, 0);
        check_val("t2_id0_timeout", res_timeout, 1);
        repeat (2) tick();
        check_val("t2_still_stalled", in_ready, 0);
        handshake();
        push_frame(fc);
        wait_res(200);
        check_val("t2_id1", res_frame_id, 1);
        handshake();
        wait_res(200);
        check_val("t2_id2", res_frame_id, 2);
        handshake();

        // Seal slot 1 on the same edge that slot 0 is released
        do_reset();
        push_frame(mk_seq(500));
        fe = mk_seq(600);
        for (int k = 0; k < 6; k++) push_pt(fe[k*20 +: 20]);
        in_valid = 1'b0;
        wait_res(200);
        check_val("t5_id0", res_frame_id, 0);
        in_x      = fe[6*20+10 +: 10];
        in_y      = fe[6*20 +: 10];
        in_valid  = 1'b1;
        res_ready = 1'b1;
        check_val("t5_ready_before", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        res_ready = 1'b0;
        exp_q.push_back(fe);
        check_val("t5_slot0_freed", in_ready, 1);
        check_val("t5_idle", busy, 0);
        check_val("t5_id1", res_frame_id, 1);
        tick();
        check_val("t5_send_started", busy, 1);
        ff = mk_seq(700);
        push_frame(ff);
        check_val("t5_slot1_full", in_ready, 0);
        wait_res(200);
        check_val("t5_e_id", res_frame_id, 1);
        handshake();
        wait_res(200);
        check_val("t5_f_id", res_frame_id, 2);
        handshake();

        // Asynchronous reset mid-SEND with a partial frame buffered
        push_frame(mk_seq(800));
        fi = mk_seq(850);
        for (int k = 0; k < 4; k++) push_pt(fi[k*20 +: 20]);
        in_valid = 1'b0;
        check_val("t6_busy_before", busy, 1);
        check_val("t6_gf_nonzero", (gf_x != 10'd0), 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_in_ready", in_ready, 1);
        check_val("t6_gf_x", gf_x, 0);
        check_val("t6_gf_y", gf_y, 0);
        check_val("t6_res_valid", res_valid, 0);
        check_val("t6_res_inside", res_inside, 0);
        check_val("t6_res_timeout", res_timeout, 0);
        check_val("t6_frame_id", res_frame_id, 3'd0);
        check_val("t6_busy", busy, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        tick();
        push_frame(mk_seq(900));
        wait_res(200);
        check_val("t6_new_id", res_frame_id, 0);
        handshake();
        repeat (3) tick();

        check_val("frames_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
